// File: rtl/hs_rr_collector_pkg.sv
// ---------------------------------------------------------------------------
// hs_pkg
// Shared definitions for the round-robin req/ack collector slice.
//   ch_state_e  : per-channel handshake state (idle / acknowledging)
//   HS_MAX_NCH  : largest supported channel count
//   HS_DEF_SYNC : default depth of each req synchroniser
//   hs_cw()     : channel-id width for a given channel count
// ---------------------------------------------------------------------------
package hs_pkg;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_ACK  = 1'b1
    } ch_state_e;

    localparam int HS_MAX_NCH  = 16;
    localparam int HS_DEF_SYNC = 2;

    // A single channel still needs a one-bit id field, so never return 0.
    function automatic int hs_cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hs_rr_collector_if.sv
// ---------------------------------------------------------------------------
// hs_rr_collector_if
// Bundles the per-channel 4-phase handshake inputs and the single output
// valid/ready stream of the collector.
//   ch_req    : per-channel level request from the sources
//   ch_data   : per-channel data, channel k at [k*DW +: DW]
//   ch_ack    : per-channel acknowledge back to the sources
//   out_valid : output word present
//   out_ready : consumer accepts the word
//   out_data  : captured word
//   out_ch    : index of the channel that supplied out_data
// Modports:
//   master : the side that drives requests/data and consumes the stream
//   slave  : the collector itself
// ---------------------------------------------------------------------------
interface hs_rr_collector_if
    import hs_pkg::*;
#(
    parameter int DW  = 4,
    parameter int NCH = 4
);

    localparam int CW = hs_cw(NCH);

    logic [NCH-1:0]    ch_req;
    logic [NCH*DW-1:0] ch_data;
    logic [NCH-1:0]    ch_ack;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     out_ch;

    modport master (
        output ch_req,
        output ch_data,
        output out_ready,
        input  ch_ack,
        input  out_valid,
        input  out_data,
        input  out_ch
    );

    modport slave (
        input  ch_req,
        input  ch_data,
        input  out_ready,
        output ch_ack,
        output out_valid,
        output out_data,
        output out_ch
    );

endinterface

// File: rtl/hs_rr_collector_arbiter.sv
// ---------------------------------------------------------------------------
// hs_rr_arbiter
// Round-robin arbiter with an internal rotating pointer. When enabled and at
// least one channel is pending, the first pending channel at or above the
// pointer (wrapping modulo NCH) wins; the pointer then moves to winner+1.
//   clk, rst_n  : clock and asynchronous active-low reset
//   pending     : request vector, one bit per channel
//   enable      : arbitration permitted this cycle (output slot free)
//   grant       : one-hot winner
//   grant_idx   : binary index of the winner
//   grant_valid : a winner exists this cycle
// ---------------------------------------------------------------------------
module hs_rr_arbiter
    import hs_pkg::*;
#(
    parameter int NCH = 4,
    localparam int CW = hs_cw(NCH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] pending,
    input  logic           enable,
    output logic [NCH-1:0] grant,
    output logic [CW-1:0]  grant_idx,
    output logic           grant_valid
);

    logic [CW-1:0] rr_ptr;
    logic [CW-1:0] ptr_next;

    // Scan NCH candidates starting at the pointer; the first pending one
    // found wins and later candidates are ignored.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            int            j;
            logic [CW-1:0] cand;
            j = int'(rr_ptr) + i;
            if (j >= NCH) begin
                j = j - NCH;
            end
            cand = CW'(j);
            if (enable && !grant_valid && pending[cand]) begin
                grant_valid = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // The wrap is explicit because NCH need not be a power of two.
    always_comb begin
        ptr_next = rr_ptr;
        if (grant_valid) begin
            if (grant_idx == CW'(NCH - 1)) begin
                ptr_next = '0;
            end else begin
                ptr_next = grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/hs_rr_collector.sv
// ---------------------------------------------------------------------------
// hs_rr_collector
// N-channel 4-phase req/ack receiver. Each request is synchronised into the
// local clock domain, pending channels are arbitrated round-robin, and the
// winner's data is captured into a single output register presented as a
// valid/ready stream tagged with the source channel id.
//   clk   : sole clock
//   rst_n : asynchronous active-low reset
//   bus   : hs_rr_collector_if.slave (ch_req, ch_data, ch_ack,
//           out_valid, out_ready, out_data, out_ch)
// Parameters:
//   DW          : data width per channel
//   NCH         : number of channels (2..HS_MAX_NCH)
//   SYNC_STAGES : flops per req synchroniser; 0 uses req directly
// ---------------------------------------------------------------------------
module hs_rr_collector
    import hs_pkg::*;
#(
    parameter int DW          = 4,
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = HS_DEF_SYNC
) (
    input  logic              clk,
    input  logic              rst_n,
    hs_rr_collector_if.slave  bus
);

    localparam int CW = hs_cw(NCH);

    logic [NCH-1:0] req_s;
    logic [NCH-1:0] pending;
    logic [NCH-1:0] ack_vec;
    logic [NCH-1:0] grant;
    logic [CW-1:0]  grant_idx;
    logic           grant_valid;
    logic           slot_free;
    logic [DW-1:0]  cap_data;

    ch_state_e      state_q [NCH];
    ch_state_e      state_d [NCH];

    logic           out_valid_q;
    logic [DW-1:0]  out_data_q;
    logic [CW-1:0]  out_ch_q;

    // Request synchronisers. With zero stages the sources share our clock
    // and the request is used as-is.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign req_s = bus.ch_req;
        end else begin : g_sync
            logic [NCH-1:0] sync_q [SYNC_STAGES];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < SYNC_STAGES; s++) begin
                        sync_q[s] <= '0;
                    end
                end else begin
                    sync_q[0] <= bus.ch_req;
                    for (int s = 1; s < SYNC_STAGES; s++) begin
                        sync_q[s] <= sync_q[s-1];
                    end
                end
            end

            assign req_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // A channel competes only while idle; once acknowledged it must see its
    // request drop before it can be captured again.
    always_comb begin
        pending = '0;
        ack_vec = '0;
        for (int k = 0; k < NCH; k++) begin
            pending[k] = (state_q[k] == CH_IDLE) && req_s[k];
            ack_vec[k] = (state_q[k] == CH_ACK);
        end
    end

    // The slot can take a new word if it is empty or is being drained now,
    // which lets a drain and a grant share one cycle without a bubble.
    assign slot_free = !out_valid_q || bus.out_ready;

    hs_rr_arbiter #(
        .NCH (NCH)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .pending     (pending),
        .enable      (slot_free),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Next-state for every channel: idle moves to ack only when granted,
    // ack returns to idle once the synchronised request has fallen.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            state_d[k] = state_q[k];
            case (state_q[k])
                CH_IDLE: begin
                    if (grant[k]) begin
                        state_d[k] = CH_ACK;
                    end
                end
                CH_ACK: begin
                    if (!req_s[k]) begin
                        state_d[k] = CH_IDLE;
                    end
                end
                default: begin
                    state_d[k] = CH_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                state_q[k] <= CH_IDLE;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                state_q[k] <= state_d[k];
            end
        end
    end

    // Data mux driven by the one-hot grant keeps all slice bounds constant.
    always_comb begin
        cap_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (grant[k]) begin
                cap_data = bus.ch_data[k*DW +: DW];
            end
        end
    end

    // Output register: a grant always loads a fresh word; otherwise a
    // completed transfer empties the slot but leaves data/id untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else if (grant_valid) begin
            out_valid_q <= 1'b1;
            out_data_q  <= cap_data;
            out_ch_q    <= grant_idx;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.ch_ack    = ack_vec;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_hs_rr_collector.sv
// ---------------------------------------------------------------------------
// tb_hs_rr_collector
// Directed bench for hs_rr_collector. dut_a is the default 4-channel,
// two-stage-synchroniser build; dut_b is a 2-channel build with no
// synchroniser. Words expected on dut_a's output stream are queued as the
// requests are driven and matched against every accepted transfer.
// ---------------------------------------------------------------------------
module tb_hs_rr_collector;
    import hs_pkg::*;

    typedef struct packed {
        logic [1:0] ch;
        logic [3:0] data;
    } sb_item_t;

    logic clk = 1'b0;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    sb_item_t sb_q [$];
    sb_item_t sb_exp;

    always #5 clk = ~clk;

    hs_rr_collector_if #(.DW(4), .NCH(4)) bus_a ();
    hs_rr_collector_if #(.DW(4), .NCH(2)) bus_b ();

    hs_rr_collector #(
        .DW          (4),
        .NCH         (4),
        .SYNC_STAGES (2)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    hs_rr_collector #(
        .DW          (4),
        .NCH         (2),
        .SYNC_STAGES (0)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n active edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int ch, input logic req, input logic [3:0] data);
        bus_a.ch_data[ch*4 +: 4] = data;
        bus_a.ch_req[ch]         = req;
    endtask

    task automatic expect_word(input logic [1:0] ch, input logic [3:0] data);
        sb_item_t it;
        it.ch   = ch;
        it.data = data;
        sb_q.push_back(it);
    endtask

    // Every accepted transfer on dut_a must match the oldest queued word.
    always @(negedge clk) begin
        if (rst_n && bus_a.out_valid && bus_a.out_ready) begin
            check_output("sb_nonempty", (sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                sb_exp = sb_q.pop_front();
                check_output("sb_ch", bus_a.out_ch, sb_exp.ch);
                check_output("sb_data", bus_a.out_data, sb_exp.data);
            end
        end
    end

    initial begin
        rst_n           = 1'b0;
        bus_a.ch_req    = '0;
        bus_a.ch_data   = '0;
        bus_a.out_ready = 1'b1;
        bus_b.ch_req    = '0;
        bus_b.ch_data   = '0;
        bus_b.out_ready = 1'b1;

        // Reset state
        step(2);
        check_output("rst_ack", bus_a.ch_ack, 0);
        check_output("rst_valid", bus_a.out_valid, 0);
        check_output("rst_data", bus_a.out_data, 0);
        check_output("rst_ch", bus_a.out_ch, 0);
        check_output("rst_b_valid", bus_b.out_valid, 0);
        rst_n = 1'b1;

        // All four channels at once: ch0..ch3 back to back, no bubbles
        $display("[TB] all-channel burst");
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(k, 1'b1, 4'(k + 1));
            expect_word(2'(k), 4'(k + 1));
        end
        step(2);
        check_output("burst_wait_valid", bus_a.out_valid, 0);
        for (int k = 0; k < 4; k++) begin
            step(1);
            check_output("burst_valid", bus_a.out_valid, 1);
            check_output("burst_ch", bus_a.out_ch, k);
            check_output("burst_ack", bus_a.ch_ack, (1 << (k + 1)) - 1);
        end
        step(1);
        check_output("burst_drained", bus_a.out_valid, 0);
        bus_a.ch_req = '0;
        step(2);
        check_output("burst_ack_hold", bus_a.ch_ack, 4'hF);
        step(1);
        check_output("burst_ack_fall", bus_a.ch_ack, 0);

        // Single channel latency (pointer back at 0, so ch1 is uncontested)
        $display("[TB] single channel latency");
        apply_stimulus(1, 1'b1, 4'hA);
        expect_word(2'd1, 4'hA);
        step(2);
        check_output("lat_ack_early", bus_a.ch_ack, 0);
        check_output("lat_valid_early", bus_a.out_valid, 0);
        step(1);
        check_output("lat_ack", bus_a.ch_ack, 4'b0010);
        check_output("lat_valid", bus_a.out_valid, 1);
        check_output("lat_data", bus_a.out_data, 4'hA);
        check_output("lat_ch", bus_a.out_ch, 1);
        apply_stimulus(1, 1'b0, 4'hA);
        step(1);
        check_output("drain_valid", bus_a.out_valid, 0);
        check_output("drain_data_kept", bus_a.out_data, 4'hA);
        check_output("drain_ch_kept", bus_a.out_ch, 1);
        step(1);
        check_output("fall_ack_hold", bus_a.ch_ack, 4'b0010);
        step(1);
        check_output("fall_ack", bus_a.ch_ack, 0);

        // Backpressure: ch0 held in the slot, ch2 waits without ack
        $display("[TB] backpressure");
        bus_a.out_ready = 1'b0;
        apply_stimulus(0, 1'b1, 4'h5);
        expect_word(2'd0, 4'h5);
        step(3);
        check_output("bp_ch0_ch", bus_a.out_ch, 0);
        check_output("bp_ch0_data", bus_a.out_data, 4'h5);
        apply_stimulus(2, 1'b1, 4'h6);
        step(4);
        check_output("bp_hold_valid", bus_a.out_valid, 1);
        check_output("bp_hold_data", bus_a.out_data, 4'h5);
        check_output("bp_hold_ack", bus_a.ch_ack, 4'b0001);
        bus_a.out_ready = 1'b1;
        expect_word(2'd2, 4'h6);
        step(1);
        bus_a.out_ready = 1'b0;
        check_output("bp_swap_valid", bus_a.out_valid, 1);
        check_output("bp_swap_data", bus_a.out_data, 4'h6);
        check_output("bp_swap_ch", bus_a.out_ch, 2);
        check_output("bp_swap_ack", bus_a.ch_ack, 4'b0101);
        apply_stimulus(0, 1'b0, 4'h5);
        apply_stimulus(2, 1'b0, 4'h6);
        bus_a.out_ready = 1'b1;
        step(1);
        check_output("bp_drained", bus_a.out_valid, 0);
        step(2);
        check_output("bp_ack_fall", bus_a.ch_ack, 0);

        // Grant ch3 once so the pointer wraps to 0
        apply_stimulus(3, 1'b1, 4'h8);
        expect_word(2'd3, 4'h8);
        step(3);
        check_output("wrap_ch", bus_a.out_ch, 3);
        check_output("wrap_ack", bus_a.ch_ack, 4'b1000);
        apply_stimulus(3, 1'b0, 4'h8);
        step(3);
        check_output("wrap_ack_fall", bus_a.ch_ack, 0);

        // Fairness: ch3 waits while ch0 completes and re-requests
        $display("[TB] fairness");
        bus_a.out_ready = 1'b0;
        apply_stimulus(0, 1'b1, 4'h7);
        apply_stimulus(3, 1'b1, 4'hB);
        expect_word(2'd0, 4'h7);
        step(3);
        check_output("fair_first_ch", bus_a.out_ch, 0);
        check_output("fair_first_ack", bus_a.ch_ack, 4'b0001);
        apply_stimulus(0, 1'b0, 4'h7);
        step(3);
        check_output("fair_ack0_fall", bus_a.ch_ack, 0);
        apply_stimulus(0, 1'b1, 4'hC);
        step(2);
        check_output("fair_hold_data", bus_a.out_data, 4'h7);
        bus_a.out_ready = 1'b1;
        expect_word(2'd3, 4'hB);
        expect_word(2'd0, 4'hC);
        step(1);
        check_output("fair_ch3_ch", bus_a.out_ch, 3);
        check_output("fair_ch3_data", bus_a.out_data, 4'hB);
        check_output("fair_ch3_ack", bus_a.ch_ack, 4'b1000);
        step(1);
        check_output("fair_ch0_ch", bus_a.out_ch, 0);
        check_output("fair_ch0_data", bus_a.out_data, 4'hC);
        check_output("fair_ch0_ack", bus_a.ch_ack, 4'b1001);
        apply_stimulus(0, 1'b0, 4'hC);
        apply_stimulus(3, 1'b0, 4'hB);
        step(1);
        check_output("fair_drained", bus_a.out_valid, 0);
        step(2);
        check_output("fair_ack_fall", bus_a.ch_ack, 0);

        // Reset while ch1 is acknowledged and its word is still held
        $display("[TB] reset mid-transfer");
        bus_a.out_ready = 1'b0;
        apply_stimulus(1, 1'b1, 4'hD);
        expect_word(2'd1, 4'hD);
        step(3);
        check_output("mid_ack", bus_a.ch_ack, 4'b0010);
        check_output("mid_valid", bus_a.out_valid, 1);
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_ack", bus_a.ch_ack, 0);
        check_output("mid_rst_valid", bus_a.out_valid, 0);
        check_output("mid_rst_data", bus_a.out_data, 0);
        check_output("mid_rst_ch", bus_a.out_ch, 0);
        void'(sb_q.pop_back());
        step(2);
        rst_n = 1'b1;
        bus_a.out_ready = 1'b1;
        expect_word(2'd1, 4'hD);
        step(2);
        check_output("recap_ack_early", bus_a.ch_ack, 0);
        check_output("recap_valid_early", bus_a.out_valid, 0);
        step(1);
        check_output("recap_ack", bus_a.ch_ack, 4'b0010);
        check_output("recap_valid", bus_a.out_valid, 1);
        check_output("recap_data", bus_a.out_data, 4'hD);
        apply_stimulus(1, 1'b0, 4'hD);
        step(3);
        check_output("recap_ack_fall", bus_a.ch_ack, 0);
        check_output("recap_drained", bus_a.out_valid, 0);

        // Unsynchronised build: one-edge latency
        $display("[TB] zero-stage synchroniser");
        bus_b.ch_data[3:0] = 4'h3;
        bus_b.ch_req[0]    = 1'b1;
        step(1);
        check_output("nosync_ack", bus_b.ch_ack, 2'b01);
        check_output("nosync_valid", bus_b.out_valid, 1);
        check_output("nosync_data", bus_b.out_data, 4'h3);
        check_output("nosync_ch", bus_b.out_ch, 0);
        bus_b.ch_req[0] = 1'b0;
        step(1);
        check_output("nosync_ack_fall", bus_b.ch_ack, 0);
        check_output("nosync_drained", bus_b.out_valid, 0);

        step(1);
        check_output("sb_leftover", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
